// File: rtl/snn_upsample2d_if.sv
// Stream interface carrying packed {valid, ch, y, x} spike beats for snn_upsample2d.
interface snn_upsample2d_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/snn_upsample2d.sv
// Nearest-neighbour 2D upsampler for address-event spikes: each spike becomes SCALE*SCALE beats.
// Status counters are built only when SNN_UPSAMPLE_STATS_EN is defined; otherwise they read 0.
module snn_upsample2d #(
    parameter int INPUT_WIDTH    = 14,
    parameter int INPUT_HEIGHT   = 14,
    parameter int INPUT_CHANNELS = 32,
    parameter int SCALE          = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    snn_upsample2d_if.slave         s_axis_input,
    snn_upsample2d_if.master        m_axis_output,
    output logic                    busy,
    output logic [31:0]             input_spike_count,
    output logic [31:0]             output_spike_count,
    output logic [31:0]             drop_count
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] MARK   = 2'd2;

    localparam logic [8:0] W_LIM    = 9'(INPUT_WIDTH);
    localparam logic [8:0] H_LIM    = 9'(INPUT_HEIGHT);
    localparam logic [8:0] C_LIM    = 9'(INPUT_CHANNELS);
    localparam logic [7:0] SCALE_B  = 8'(SCALE);
    localparam logic [2:0] LAST_IDX = 3'(SCALE - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] ch_q, ch_d;
    logic [7:0] y_q, y_d;
    logic [7:0] x_q, x_d;
    logic       last_q, last_d;
    logic [2:0] dx_q, dx_d;
    logic [2:0] dy_q, dy_d;

    logic [7:0] in_valid, in_ch, in_y, in_x;
    logic       in_fire, out_fire, is_spike, at_last;

    assign {in_valid, in_ch, in_y, in_x} = s_axis_input.tdata;

    always_comb begin
        s_axis_input.tready = (state_q == IDLE) && enable && !reset;
        in_fire  = s_axis_input.tvalid && s_axis_input.tready;
        is_spike = (in_valid != 8'h00) && ({1'b0, in_ch} < C_LIM) &&
                   ({1'b0, in_y} < H_LIM) && ({1'b0, in_x} < W_LIM);
        at_last  = (dx_q == LAST_IDX) && (dy_q == LAST_IDX);
        busy     = (state_q != IDLE);

        m_axis_output.tvalid = (state_q == EXPAND) || (state_q == MARK);
        // Enable gates the handshake itself so a stalled beat cannot be consumed while paused.
        out_fire = m_axis_output.tvalid && m_axis_output.tready && enable;

        m_axis_output.tdata = '0;
        m_axis_output.tlast = 1'b0;
        if (state_q == EXPAND) begin
            m_axis_output.tdata = {8'h01, ch_q, y_q * SCALE_B + {5'b0, dy_q},
                                   x_q * SCALE_B + {5'b0, dx_q}};
            m_axis_output.tlast = last_q && at_last;
        end else if (state_q == MARK) begin
            m_axis_output.tlast = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        y_d     = y_q;
        x_d     = x_q;
        last_d  = last_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    if (is_spike) begin
                        state_d = EXPAND;
                        ch_d    = in_ch;
                        y_d     = in_y;
                        x_d     = in_x;
                        last_d  = s_axis_input.tlast;
                        dx_d    = '0;
                        dy_d    = '0;
                    end else if (s_axis_input.tlast) begin
                        state_d = MARK;
                    end
                end
            end
            EXPAND: begin
                if (out_fire) begin
                    if (dx_q == LAST_IDX) begin
                        dx_d = '0;
                        if (dy_q == LAST_IDX) begin
                            dy_d    = '0;
                            state_d = IDLE;
                        end else begin
                            dy_d = dy_q + 3'd1;
                        end
                    end else begin
                        dx_d = dx_q + 3'd1;
                    end
                end
            end
            MARK: begin
                if (out_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ch_q    <= '0;
            y_q     <= '0;
            x_q     <= '0;
            last_q  <= 1'b0;
            dx_q    <= '0;
            dy_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            y_q     <= y_d;
            x_q     <= x_d;
            last_q  <= last_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
        end
    end

`ifdef SNN_UPSAMPLE_STATS_EN
    logic [31:0] in_cnt_q, in_cnt_d;
    logic [31:0] out_cnt_q, out_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (in_fire && is_spike)            in_cnt_d   = in_cnt_q + 32'd1;
        if (in_fire && !is_spike)           drop_cnt_d = drop_cnt_q + 32'd1;
        if (out_fire && state_q == EXPAND)  out_cnt_d  = out_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign input_spike_count  = in_cnt_q;
    assign output_spike_count = out_cnt_q;
    assign drop_count         = drop_cnt_q;
`else
    assign input_spike_count  = '0;
    assign output_spike_count = '0;
    assign drop_count         = '0;
`endif
endmodule

// File: tb/tb_snn_upsample2d.sv
// Directed bench for snn_upsample2d: vector table plus stall, enable-pause, reset and SCALE=1 sequences.
module tb_snn_upsample2d;
    typedef struct {
        logic [31:0]       din;
        logic              lin;
        int unsigned       n;
        logic [3:0][31:0]  dout;
        logic [3:0]        lout;
    } vec_t;

`ifdef SNN_UPSAMPLE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, enable;
    logic busy, busy1;
    logic [31:0] in_cnt, out_cnt, drop_cnt, in_cnt1, out_cnt1, drop_cnt1;
    int unsigned checks = 0;
    int unsigned errors = 0;
    vec_t vecs[9];

    snn_upsample2d_if s_if ();
    snn_upsample2d_if m_if ();
    snn_upsample2d_if s1_if ();
    snn_upsample2d_if m1_if ();

    snn_upsample2d #(.INPUT_WIDTH(14), .INPUT_HEIGHT(14), .INPUT_CHANNELS(32), .SCALE(2)) u_dut (
        .clk(clk), .reset(reset), .enable(enable),
        .s_axis_input(s_if.slave), .m_axis_output(m_if.master), .busy(busy),
        .input_spike_count(in_cnt), .output_spike_count(out_cnt), .drop_count(drop_cnt)
    );

    snn_upsample2d #(.INPUT_WIDTH(14), .INPUT_HEIGHT(14), .INPUT_CHANNELS(32), .SCALE(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable),
        .s_axis_input(s1_if.slave), .m_axis_output(m1_if.master), .busy(busy1),
        .input_spike_count(in_cnt1), .output_spike_count(out_cnt1), .drop_count(drop_cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] din, input logic lin, input int unsigned n,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3, input logic [3:0] lout);
        vec_t v;
        v.din = din; v.lin = lin; v.n = n;
        v.dout[0] = d0; v.dout[1] = d1; v.dout[2] = d2; v.dout[3] = d3;
        v.lout = lout;
        return v;
    endfunction

    function automatic logic [63:0] beat(input logic v, input logic l, input logic [31:0] d);
        return {30'b0, v, l, d};
    endfunction

    task automatic send(input logic [31:0] d, input logic l);
        int unsigned w = 0;
        @(negedge clk);
        while (!s_if.tready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("send_tready", 64'(s_if.tready), 64'(1));
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        @(posedge clk);
        #1 s_if.tvalid = 1'b0;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check(name, {62'b0, s_if.tready, m_if.tvalid}, 64'b10);
    endtask

    initial begin
        vec_t v;
        int unsigned idx, cyc;
        logic tr;

        vecs[0] = mk(32'h01050304, 1'b0, 4, 32'h01050608, 32'h01050609, 32'h01050708, 32'h01050709, 4'b0000);
        vecs[1] = mk(32'h01050304, 1'b1, 4, 32'h01050608, 32'h01050609, 32'h01050708, 32'h01050709, 4'b1000);
        vecs[2] = mk(32'h00050304, 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
        vecs[3] = mk(32'h01200000, 1'b1, 1, 32'h00000000, 32'h0, 32'h0, 32'h0, 4'b0001);
        vecs[4] = mk(32'h010D0D0D, 1'b0, 4, 32'h010D1A1A, 32'h010D1A1B, 32'h010D1B1A, 32'h010D1B1B, 4'b0000);
        vecs[5] = mk(32'h011F0000, 1'b1, 4, 32'h011F0000, 32'h011F0001, 32'h011F0100, 32'h011F0101, 4'b1000);
        vecs[6] = mk(32'h01000E00, 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
        vecs[7] = mk(32'h0100000E, 1'b1, 1, 32'h00000000, 32'h0, 32'h0, 32'h0, 4'b0001);
        vecs[8] = mk(32'hFF000000, 1'b0, 4, 32'h01000000, 32'h01000001, 32'h01000100, 32'h01000101, 4'b0000);

        reset = 1'b1; enable = 1'b1;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b1;
        s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tlast = 1'b0; m1_if.tready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_tready", 64'(s_if.tready), 64'(0));
        check("rst_out", {29'b0, busy, m_if.tvalid, m_if.tlast, m_if.tdata}, 64'(0));
        check("rst_counts", {in_cnt, out_cnt | drop_cnt}, 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("rel_tready", 64'(s_if.tready), 64'(1));

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            send(v.din, v.lin);
            for (int b = 0; b < int'(v.n); b++) begin
                @(negedge clk);
                check($sformatf("vec%0d_beat%0d", i, b),
                      beat(m_if.tvalid, m_if.tlast, m_if.tdata), beat(1'b1, v.lout[b], v.dout[b]));
            end
            check_idle($sformatf("vec%0d_idle", i));
        end
        check("cnt_in", 64'(in_cnt), STATS ? 64'(5) : 64'(0));
        check("cnt_out", 64'(out_cnt), STATS ? 64'(20) : 64'(0));
        check("cnt_drop", 64'(drop_cnt), STATS ? 64'(4) : 64'(0));

        // Output backpressure toggling every cycle
        v = vecs[1];
        send(v.din, v.lin);
        idx = 0; cyc = 0; tr = 1'b0;
        while (idx < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            tr = ~tr;
            m_if.tready = tr;
            check($sformatf("stall_beat%0d", idx),
                  beat(m_if.tvalid, m_if.tlast, m_if.tdata), beat(1'b1, v.lout[idx], v.dout[idx]));
            if (tr) idx++;
        end
        m_if.tready = 1'b1;
        check("stall_done", 64'(idx), 64'(4));
        check_idle("stall_idle");

        // Enable dropped while the second beat is pending
        v = vecs[0];
        send(v.din, v.lin);
        @(negedge clk);
        check("en_beat0", beat(m_if.tvalid, m_if.tlast, m_if.tdata), beat(1'b1, 1'b0, v.dout[0]));
        @(negedge clk);
        check("en_beat1", beat(m_if.tvalid, m_if.tlast, m_if.tdata), beat(1'b1, 1'b0, v.dout[1]));
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("en_hold%0d", k),
                  {s_if.tready, busy, beat(m_if.tvalid, m_if.tlast, m_if.tdata)[61:0]},
                  {1'b0, 1'b1, beat(1'b1, 1'b0, v.dout[1])[61:0]});
        end
        enable = 1'b1;
        @(negedge clk);
        check("en_beat2", beat(m_if.tvalid, m_if.tlast, m_if.tdata), beat(1'b1, 1'b0, v.dout[2]));
        @(negedge clk);
        check("en_beat3", beat(m_if.tvalid, m_if.tlast, m_if.tdata), beat(1'b1, 1'b0, v.dout[3]));
        check_idle("en_idle");
        check("cnt_out_en", 64'(out_cnt), STATS ? 64'(28) : 64'(0));

        // Reset in the middle of an expansion
        send(v.din, v.lin);
        @(negedge clk);
        check("rx_beat0", beat(m_if.tvalid, m_if.tlast, m_if.tdata), beat(1'b1, 1'b0, v.dout[0]));
        @(negedge clk);
        check("rx_beat1", beat(m_if.tvalid, m_if.tlast, m_if.tdata), beat(1'b1, 1'b0, v.dout[1]));
        reset = 1'b1;
        @(negedge clk);
        check("rx_out", {29'b0, busy, m_if.tvalid, m_if.tlast, m_if.tdata}, 64'(0));
        check("rx_counts", {in_cnt, out_cnt | drop_cnt}, 64'(0));
        check("rx_tready", 64'(s_if.tready), 64'(0));
        reset = 1'b0;
        for (int k = 0; k < 3; k++) check_idle($sformatf("rx_after%0d", k));

        // SCALE=1 pass-through instance
        @(negedge clk);
        s1_if.tdata = 32'h01050304; s1_if.tlast = 1'b1; s1_if.tvalid = 1'b1;
        @(posedge clk);
        #1 s1_if.tvalid = 1'b0;
        @(negedge clk);
        check("s1_beat", beat(m1_if.tvalid, m1_if.tlast, m1_if.tdata), beat(1'b1, 1'b1, 32'h01050304));
        @(negedge clk);
        check("s1_idle", {62'b0, s1_if.tready, m1_if.tvalid}, 64'b10);
        check("s1_cnt", {in_cnt1, out_cnt1}, STATS ? {32'd1, 32'd1} : 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/snn_upsample2d.md
SNN_UPSAMPLE2D -- requirements
Module: snn_upsample2d

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 14, input map width; INPUT_WIDTH*SCALE SHALL be <= 256.
REQ-002 SHALL have parameter INPUT_HEIGHT, default 14, input map height; INPUT_HEIGHT*SCALE SHALL be <= 256.
REQ-003 SHALL have parameter INPUT_CHANNELS, default 32, channel count, <= 256.
REQ-004 SHALL have parameter SCALE, default 2, replication factor per axis, 1..8.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 enable  input  1  pauses all state advance when low.
REQ-008 s_axis_input_tdata  input  32  {valid[31:24], ch[23:16], y[15:8], x[7:0]}.
REQ-009 s_axis_input_tvalid  input  1; s_axis_input_tready  output  1; s_axis_input_tlast  input  1.
REQ-010 m_axis_output_tdata  output  32  same packing as input; m_axis_output_tvalid  output  1; m_axis_output_tready  input  1; m_axis_output_tlast  output  1.
REQ-011 busy  output  1  high when not in IDLE.
REQ-012 input_spike_count, output_spike_count, drop_count  output  32 each  status counters.

Function
REQ-013 FSM states SHALL be IDLE, EXPAND, MARK.
REQ-014 s_axis_input_tready SHALL be high only in IDLE with enable high; a beat is accepted when tvalid and tready are both high.
REQ-015 Accepted beat is a spike if valid byte != 0, ch < INPUT_CHANNELS, y < INPUT_HEIGHT, x < INPUT_WIDTH; otherwise it is a drop.
REQ-016 Spike accepted in cycle N: ch/x/y/tlast latched; FSM -> EXPAND; first output beat valid at N+1.
REQ-017 EXPAND SHALL emit SCALE*SCALE beats {8'h01, ch, y*SCALE+dy, x*SCALE+dx}, dx inner loop 0..SCALE-1, dy outer loop 0..SCALE-1.
REQ-018 Output beat SHALL advance only when m_axis_output_tvalid and m_axis_output_tready are both high; tdata/tlast SHALL stay stable while tvalid is high and tready is low.
REQ-019 m_axis_output_tlast SHALL be 1 only on the final (dx=dy=SCALE-1) beat of a spike whose input tlast was 1.
REQ-020 After the final beat handshakes, FSM -> IDLE; tready is high the next cycle, giving SCALE*SCALE+1 cycles per spike with tready held high.
REQ-021 Drop without tlast: no output; FSM stays IDLE; drop_count increments.
REQ-022 Drop with tlast: FSM -> MARK; emit one beat tdata=32'h0, tlast=1; return to IDLE on handshake; drop_count increments.
REQ-023 enable low: no input accept, no dx/dy/FSM advance; a pending output beat keeps tvalid and tdata held, and a handshake on that beat SHALL NOT be completed until enable returns.
REQ-024 Counters increment by 1 per accepted spike (input), per handshaked spike beat (output; the MARK beat is excluded), and per drop, wrapping modulo 2^32.
REQ-025 SCALE=1 SHALL pass each spike through unchanged with 1-cycle latency.

Reset
REQ-026 On reset: FSM=IDLE, s_axis_input_tready=0 during reset, m_axis_output_tvalid=0, m_axis_output_tlast=0, m_axis_output_tdata=0, busy=0, dx=dy=0, all counters=0.
REQ-027 Reset mid-EXPAND SHALL abandon remaining beats with no further output.
REQ-028 After reset deasserts, tready=1 the next cycle if enable is high.

Configuration
REQ-029 With macro SNN_UPSAMPLE_STATS_EN defined, the three counters SHALL operate per REQ-024.
REQ-030 Without SNN_UPSAMPLE_STATS_EN, the three counters SHALL be constant 0 and no counter registers are built; all other behaviour is unchanged.

Verification
REQ-031 SCALE=2; input 0x01050304, tlast=0, tready=1 -> outputs 0x01050608, 0x01050609, 0x01050708, 0x01050709 on consecutive cycles, all tlast=0.
REQ-032 Same input with tlast=1 and output tready toggling 1/0 -> same 4 beats in order with tdata held during stalls; tlast=1 only on 0x01050709.
REQ-033 Input 0x00050304 tlast=0, then 0x01200000 (ch=32) tlast=1 -> no spike output; one beat 0x00000000 with tlast=1; drop_count=2.
REQ-034 enable dropped for 5 cycles after the 2nd beat of REQ-031 -> beat 2 tvalid/tdata held, no handshake; beats 3-4 follow after enable returns.
REQ-035 reset asserted after the 2nd beat of REQ-031 -> tvalid=0 the next cycle, no further beats, counters=0, tready=1 after release.
REQ-036 Build without SNN_UPSAMPLE_STATS_EN, rerun REQ-031 -> identical outputs; all counters read 0.
